branch_predict_ctrl: RTL and testbench

BRANCH_PREDICT_CTRL -- requirements
Module: branch_predict_ctrl

---
 rtl/branch_predict_ctrl_pkg.sv | 48 ++++
 rtl/sat_counter2.sv | 29 ++
 rtl/branch_predict_ctrl.sv | 104 ++++++++++
 tb/tb_branch_predict_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predict_ctrl_pkg.sv
// Shared CPU definitions for the branch predictor: PC-source and redirect
// encodings, 2-bit counter states and the counter step function.
package branch_predict_ctrl_pkg;

  localparam int unsigned PCSRC_W = 2;
  localparam int unsigned BRSEL_W = 2;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned PERF_W  = 32;

  // EX-stage next-PC source
  typedef enum logic [PCSRC_W-1:0] {
    PCSRC_SEQ  = 2'b00,
    PCSRC_JAL  = 2'b01,
    PCSRC_JALR = 2'b10,
    PCSRC_BR   = 2'b11
  } pcsrc_e;

  // Fetch redirect select
  typedef enum logic [BRSEL_W-1:0] {
    BRSEL_PC4     = 2'b00,
    BRSEL_TGT     = 2'b01,
    BRSEL_JALR    = 2'b10,
    BRSEL_RECOVER = 2'b11
  } br_sel_e;

  // 2-bit saturating counter states; bit 1 is the taken prediction
  typedef enum logic [CNT_W-1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_e;

  localparam cnt_e CNT_RESET = CNT_WNT;

  // Saturating step toward taken (up=1) or not-taken (up=0)
  function automatic cnt_e cnt_next(input cnt_e cur, input logic up);
    cnt_e nxt;
    nxt = cur;
    if (up) begin
      if (cur != CNT_ST) nxt = cnt_e'(CNT_W'(cur) + CNT_W'(1));
    end else begin
      if (cur != CNT_SNT) nxt = cnt_e'(CNT_W'(cur) - CNT_W'(1));
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// One BHT entry: 2-bit up/down saturating counter, reset to weak-not-taken.
module sat_counter2
  import branch_predict_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  output logic [CNT_W-1:0] count
);

  cnt_e state_q;
  cnt_e state_d;

  // Next state: step only when this entry is being trained
  always_comb begin
    state_d = state_q;
    if (en) state_d = cnt_next(state_q, up);
  end

  // State register, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) state_q <= CNT_RESET;
    else      state_q <= state_d;
  end

  assign count = CNT_W'(state_q);

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch prediction controller: BHT of 2-bit counters read at fetch and
// trained at EX, redirect/flush generation and branch perf counters.
module branch_predict_ctrl
  import branch_predict_ctrl_pkg::*;
#(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DYNAMIC = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [XLEN-1:0]    F_pc,
  output logic               F_pred_taken,
  input  logic               E_valid,
  input  logic               E_stall,
  input  logic [XLEN-1:0]    E_pc,
  input  logic [PCSRC_W-1:0] E_PCSrc,
  input  logic               E_BSrc,
  input  logic               E_pred_taken,
  output logic [BRSEL_W-1:0] br_sel,
  output logic               flush,
  output logic [PERF_W-1:0]  br_cnt,
  output logic [PERF_W-1:0]  miss_cnt
);

  localparam int unsigned IDX_W  = $clog2(ENTRIES);
  localparam bit          DYN_EN = (DYNAMIC != 0);

  logic [IDX_W-1:0]              f_idx;
  logic [IDX_W-1:0]              e_idx;
  logic                          resolve;
  logic                          mispredict;
  logic [ENTRIES-1:0]            upd;
  logic [ENTRIES-1:0][CNT_W-1:0] cnt;
  logic                          unused_bits;

  // Word-aligned PC bits select the BHT entry
  assign f_idx = F_pc[IDX_W+1:2];
  assign e_idx = E_pc[IDX_W+1:2];

  // A conditional branch resolves once, in the first unstalled EX cycle
  assign resolve    = E_valid & ~E_stall & (pcsrc_e'(E_PCSrc) == PCSRC_BR);
  assign mispredict = resolve & (E_BSrc ^ E_pred_taken);

  // BHT: one saturating counter per entry; static mode never trains
  for (genvar i = 0; i < ENTRIES; i++) begin : g_bht
    assign upd[i] = DYN_EN & resolve & (e_idx == IDX_W'(i));

    sat_counter2 u_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (upd[i]),
      .up    (E_BSrc),
      .count (cnt[i])
    );
  end

  // Prediction reads the registered counter, so a same-cycle update is not seen
  assign F_pred_taken = rst & DYN_EN & cnt[f_idx][1];

  // Redirect select and flush: jumps first, then branch mispredict recovery
  always_comb begin
    br_sel = BRSEL_PC4;
    flush  = 1'b0;
    if (rst && E_valid && !E_stall) begin
      unique case (pcsrc_e'(E_PCSrc))
        PCSRC_JAL: begin
          br_sel = BRSEL_TGT;
          flush  = 1'b1;
        end
        PCSRC_JALR: begin
          br_sel = BRSEL_JALR;
          flush  = 1'b1;
        end
        PCSRC_BR: begin
          if (mispredict) begin
            br_sel = E_BSrc ? BRSEL_TGT : BRSEL_RECOVER;
            flush  = 1'b1;
          end
        end
        default: begin
          br_sel = BRSEL_PC4;
          flush  = 1'b0;
        end
      endcase
    end
  end

  // Saturating perf counters for resolved and mispredicted branches
  always_ff @(posedge clk) begin
    if (!rst) begin
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else begin
      if (resolve && (br_cnt != '1))      br_cnt   <= br_cnt + PERF_W'(1);
      if (mispredict && (miss_cnt != '1)) miss_cnt <= miss_cnt + PERF_W'(1);
    end
  end

  // PC bits outside the index and counter LSBs do not feed any logic
  assign unused_bits = ^{F_pc[XLEN-1:IDX_W+2], F_pc[1:0],
                         E_pc[XLEN-1:IDX_W+2], E_pc[1:0], cnt};

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl: dynamic and static instances.
module tb_branch_predict_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] F_pc;
  logic        E_valid;
  logic        E_stall;
  logic [31:0] E_pc;
  logic [1:0]  E_PCSrc;
  logic        E_BSrc;
  logic        E_pred_taken;

  logic        F_pred_taken;
  logic [1:0]  br_sel;
  logic        flush;
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;

  logic        s_F_pred_taken;
  logic [1:0]  s_br_sel;
  logic        s_flush;
  logic [31:0] s_br_cnt;
  logic [31:0] s_miss_cnt;

  int total;
  int bad;

  branch_predict_ctrl #(.ENTRIES(64), .XLEN(32), .DYNAMIC(1)) dut (
    .clk(clk), .rst(rst), .F_pc(F_pc), .F_pred_taken(F_pred_taken),
    .E_valid(E_valid), .E_stall(E_stall), .E_pc(E_pc), .E_PCSrc(E_PCSrc),
    .E_BSrc(E_BSrc), .E_pred_taken(E_pred_taken), .br_sel(br_sel),
    .flush(flush), .br_cnt(br_cnt), .miss_cnt(miss_cnt)
  );

  branch_predict_ctrl #(.ENTRIES(64), .XLEN(32), .DYNAMIC(0)) dut_s (
    .clk(clk), .rst(rst), .F_pc(F_pc), .F_pred_taken(s_F_pred_taken),
    .E_valid(E_valid), .E_stall(E_stall), .E_pc(E_pc), .E_PCSrc(E_PCSrc),
    .E_BSrc(E_BSrc), .E_pred_taken(E_pred_taken), .br_sel(s_br_sel),
    .flush(s_flush), .br_cnt(s_br_cnt), .miss_cnt(s_miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic [31:0] pc, input logic [1:0] src,
                          input logic bsrc, input logic pred);
    E_valid      = v;
    E_pc         = pc;
    E_PCSrc      = src;
    E_BSrc       = bsrc;
    E_pred_taken = pred;
  endtask

  // Reset outputs, reset-time resolve discarded, initial prediction
  task automatic test_reset();
    rst = 1'b0; E_stall = 1'b0; F_pc = 32'h100;
    drive_ex(1'b1, 32'h100, 2'b11, 1'b1, 1'b0);
    #1;
    total++; if (br_sel !== 2'b00) begin bad++; $display("FAIL rst_br_sel got=%b want=00", br_sel); end
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL rst_flush got=%b want=0", flush); end
    total++; if (F_pred_taken !== 1'b0) begin bad++; $display("FAIL rst_pred got=%b want=0", F_pred_taken); end
    tick(); tick();
    rst = 1'b1;
    drive_ex(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    #1;
    total++; if (F_pred_taken !== 1'b0) begin bad++; $display("FAIL init_pred got=%b want=0", F_pred_taken); end
    total++; if (br_cnt !== 32'd0) begin bad++; $display("FAIL init_br_cnt got=%0d want=0", br_cnt); end
    total++; if (miss_cnt !== 32'd0) begin bad++; $display("FAIL init_miss_cnt got=%0d want=0", miss_cnt); end
  endtask

  // Two taken resolves drive counter 01 -> 10 -> 11
  task automatic test_taken();
    tick();
    F_pc = 32'h100;
    drive_ex(1'b1, 32'h100, 2'b11, 1'b1, 1'b0);
    #1;
    total++; if (br_sel !== 2'b01) begin bad++; $display("FAIL tk1_br_sel got=%b want=01", br_sel); end
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL tk1_flush got=%b want=1", flush); end
    total++; if (F_pred_taken !== 1'b0) begin bad++; $display("FAIL tk1_pred got=%b want=0", F_pred_taken); end
    tick();
    E_pred_taken = 1'b1;
    #1;
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL tk2_flush got=%b want=0", flush); end
    total++; if (br_sel !== 2'b00) begin bad++; $display("FAIL tk2_br_sel got=%b want=00", br_sel); end
    total++; if (F_pred_taken !== 1'b1) begin bad++; $display("FAIL tk2_pred got=%b want=1", F_pred_taken); end
    tick();
    E_valid = 1'b0;
    #1;
    total++; if (F_pred_taken !== 1'b1) begin bad++; $display("FAIL tk_pred_after got=%b want=1", F_pred_taken); end
    total++; if (br_cnt !== 32'd2) begin bad++; $display("FAIL tk_br_cnt got=%0d want=2", br_cnt); end
    total++; if (miss_cnt !== 32'd1) begin bad++; $display("FAIL tk_miss_cnt got=%0d want=1", miss_cnt); end
  endtask

  // Not-taken mispredicts: 11 -> 10 -> 01, prediction reads pre-update value
  task automatic test_mispredict_nt();
    drive_ex(1'b1, 32'h100, 2'b11, 1'b0, 1'b1);
    #1;
    total++; if (br_sel !== 2'b11) begin bad++; $display("FAIL nt1_br_sel got=%b want=11", br_sel); end
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL nt1_flush got=%b want=1", flush); end
    tick();
    #1;
    total++; if (F_pred_taken !== 1'b1) begin bad++; $display("FAIL nt2_pred_pre got=%b want=1", F_pred_taken); end
    total++; if (br_sel !== 2'b11) begin bad++; $display("FAIL nt2_br_sel got=%b want=11", br_sel); end
    tick();
    E_valid = 1'b0;
    #1;
    total++; if (F_pred_taken !== 1'b0) begin bad++; $display("FAIL nt_pred_after got=%b want=0", F_pred_taken); end
    total++; if (br_cnt !== 32'd4) begin bad++; $display("FAIL nt_br_cnt got=%0d want=4", br_cnt); end
    total++; if (miss_cnt !== 32'd3) begin bad++; $display("FAIL nt_miss_cnt got=%0d want=3", miss_cnt); end
  endtask

  // 0x100 and 0x200 share index 0 and train the same counter
  task automatic test_alias();
    drive_ex(1'b1, 32'h100, 2'b11, 1'b1, 1'b0);
    tick();
    drive_ex(1'b1, 32'h200, 2'b11, 1'b1, 1'b1);
    F_pc = 32'h200;
    #1;
    total++; if (F_pred_taken !== 1'b1) begin bad++; $display("FAIL al_pred_200 got=%b want=1", F_pred_taken); end
    tick();
    drive_ex(1'b1, 32'h200, 2'b11, 1'b0, 1'b0);
    #1;
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL al_correct_flush got=%b want=0", flush); end
    tick();
    E_valid = 1'b0;
    F_pc = 32'h100;
    #1;
    total++; if (F_pred_taken !== 1'b1) begin bad++; $display("FAIL al_pred_100 got=%b want=1", F_pred_taken); end
    total++; if (br_cnt !== 32'd7) begin bad++; $display("FAIL al_br_cnt got=%0d want=7", br_cnt); end
    total++; if (miss_cnt !== 32'd4) begin bad++; $display("FAIL al_miss_cnt got=%0d want=4", miss_cnt); end
    F_pc = 32'h104;
    #1;
    total++; if (F_pred_taken !== 1'b0) begin bad++; $display("FAIL al_pred_104 got=%b want=0", F_pred_taken); end
  endtask

  // jal/jalr/sequential redirects, never counted
  task automatic test_jumps();
    tick();
    drive_ex(1'b1, 32'h40, 2'b01, 1'b1, 1'b0);
    #1;
    total++; if (br_sel !== 2'b01 || flush !== 1'b1) begin bad++; $display("FAIL jal got=%b/%b want=01/1", br_sel, flush); end
    tick();
    E_PCSrc = 2'b10;
    #1;
    total++; if (br_sel !== 2'b10 || flush !== 1'b1) begin bad++; $display("FAIL jalr got=%b/%b want=10/1", br_sel, flush); end
    tick();
    E_PCSrc = 2'b00;
    #1;
    total++; if (br_sel !== 2'b00 || flush !== 1'b0) begin bad++; $display("FAIL seq got=%b/%b want=00/0", br_sel, flush); end
    tick();
    drive_ex(1'b0, 32'h40, 2'b01, 1'b1, 1'b0);
    #1;
    total++; if (br_sel !== 2'b00 || flush !== 1'b0) begin bad++; $display("FAIL jal_invalid got=%b/%b want=00/0", br_sel, flush); end
    total++; if (br_cnt !== 32'd7) begin bad++; $display("FAIL jmp_br_cnt got=%0d want=7", br_cnt); end
  endtask

  // Branch stalled 3 cycles in EX counts and trains once when released
  task automatic test_stall();
    E_stall = 1'b1;
    drive_ex(1'b1, 32'h104, 2'b11, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (br_sel !== 2'b00 || flush !== 1'b0) begin bad++; $display("FAIL stall%0d_sel got=%b/%b want=00/0", k, br_sel, flush); end
      total++; if (br_cnt !== 32'd7) begin bad++; $display("FAIL stall%0d_br_cnt got=%0d want=7", k, br_cnt); end
      tick();
    end
    E_stall = 1'b0;
    #1;
    total++; if (br_sel !== 2'b01 || flush !== 1'b1) begin bad++; $display("FAIL unstall_sel got=%b/%b want=01/1", br_sel, flush); end
    tick();
    E_valid = 1'b0;
    F_pc = 32'h104;
    #1;
    total++; if (br_cnt !== 32'd8) begin bad++; $display("FAIL stall_br_cnt got=%0d want=8", br_cnt); end
    total++; if (miss_cnt !== 32'd5) begin bad++; $display("FAIL stall_miss_cnt got=%0d want=5", miss_cnt); end
    total++; if (F_pred_taken !== 1'b1) begin bad++; $display("FAIL stall_pred got=%b want=1", F_pred_taken); end
  endtask

  // Static instance: 5 taken branches all mispredict, prediction stays 0
  task automatic test_static();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    F_pc = 32'h300;
    for (int k = 0; k < 5; k++) begin
      drive_ex(1'b1, 32'h300, 2'b11, 1'b1, 1'b0);
      #1;
      total++; if (s_F_pred_taken !== 1'b0) begin bad++; $display("FAIL st%0d_pred got=%b want=0", k, s_F_pred_taken); end
      total++; if (s_br_sel !== 2'b01 || s_flush !== 1'b1) begin bad++; $display("FAIL st%0d_sel got=%b/%b want=01/1", k, s_br_sel, s_flush); end
      tick();
    end
    E_valid = 1'b0;
    #1;
    total++; if (s_F_pred_taken !== 1'b0) begin bad++; $display("FAIL st_pred_after got=%b want=0", s_F_pred_taken); end
    total++; if (s_miss_cnt !== 32'd5) begin bad++; $display("FAIL st_miss_cnt got=%0d want=5", s_miss_cnt); end
    total++; if (s_br_cnt !== 32'd5) begin bad++; $display("FAIL st_br_cnt got=%0d want=5", s_br_cnt); end
  endtask

  // Reset mid-run gates outputs at once, drops a coincident resolve, restores 01
  task automatic test_reset_override();
    total++; if (F_pred_taken !== 1'b1) begin bad++; $display("FAIL ro_pred_before got=%b want=1", F_pred_taken); end
    rst = 1'b0;
    drive_ex(1'b1, 32'h300, 2'b11, 1'b1, 1'b0);
    #1;
    total++; if (F_pred_taken !== 1'b0) begin bad++; $display("FAIL ro_pred_in_rst got=%b want=0", F_pred_taken); end
    total++; if (br_sel !== 2'b00 || flush !== 1'b0) begin bad++; $display("FAIL ro_sel_in_rst got=%b/%b want=00/0", br_sel, flush); end
    tick();
    rst = 1'b1;
    E_valid = 1'b0;
    #1;
    total++; if (br_cnt !== 32'd0 || miss_cnt !== 32'd0) begin bad++; $display("FAIL ro_cnts got=%0d/%0d want=0/0", br_cnt, miss_cnt); end
    total++; if (F_pred_taken !== 1'b0) begin bad++; $display("FAIL ro_pred_after got=%b want=0", F_pred_taken); end
    drive_ex(1'b1, 32'h300, 2'b11, 1'b1, 1'b0);
    tick();
    E_valid = 1'b0;
    #1;
    total++; if (F_pred_taken !== 1'b1) begin bad++; $display("FAIL ro_pred_wt got=%b want=1", F_pred_taken); end
    total++; if (br_cnt !== 32'd1 || miss_cnt !== 32'd1) begin bad++; $display("FAIL ro_cnts_after got=%0d/%0d want=1/1", br_cnt, miss_cnt); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_taken();
    test_mispredict_nt();
    test_alias();
    test_jumps();
    test_stall();
    test_static();
    test_reset_override();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
